// File: rtl/controle_jogo_rodadas.sv
// Multi-round control unit for the memory game: sequences plays and rounds against the datapath
// and aborts the game when a single move takes longer than TIMEOUT_CICLOS cycles in espera.
module controle_jogo_rodadas #(
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fim_jogada,
    input  logic       fim_rodada,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraR,
    output logic       contaR,
    output logic       registraR,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [W-1:0] LIMITE = W'(TIMEOUT_CICLOS - 1);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIO_RODADA  = 4'h2,
        ESPERA         = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMA_JOGADA = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FINAL_ACERTO   = 4'hA,
        FINAL_ERRO     = 4'hE,
        FINAL_TIMEOUT  = 4'hF
    } estado_t;

    // Kept as a plain vector so any code, legal or not, can sit in the register.
    logic [3:0]   estado;
    estado_t      proximo;
    logic [W-1:0] contagem;
    logic         estouro;

    assign estouro = (contagem == LIMITE) && !jogada;

    always_comb begin
        proximo = INICIAL;
        case (estado)
            INICIAL:        proximo = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     proximo = INICIO_RODADA;
            INICIO_RODADA:  proximo = ESPERA;
            ESPERA: begin
                if (jogada)
                    proximo = REGISTRA;
                else if (estouro)
                    proximo = FINAL_TIMEOUT;
                else
                    proximo = ESPERA;
            end
            REGISTRA:       proximo = COMPARACAO;
            COMPARACAO: begin
                if (!igual)
                    proximo = FINAL_ERRO;
                else if (!fim_jogada)
                    proximo = PROXIMA_JOGADA;
                else if (!fim_rodada)
                    proximo = PROXIMA_RODADA;
                else
                    proximo = FINAL_ACERTO;
            end
            PROXIMA_JOGADA: proximo = ESPERA;
            PROXIMA_RODADA: proximo = INICIO_RODADA;
            FINAL_ACERTO:   proximo = iniciar ? PREPARACAO : FINAL_ACERTO;
            FINAL_ERRO:     proximo = iniciar ? PREPARACAO : FINAL_ERRO;
            FINAL_TIMEOUT:  proximo = iniciar ? PREPARACAO : FINAL_TIMEOUT;
            default:        proximo = INICIAL;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet still line up with estado.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado    <= INICIAL;
            contagem  <= '0;
            zeraE     <= 1'b0;
            contaE    <= 1'b0;
            zeraR     <= 1'b0;
            contaR    <= 1'b0;
            registraR <= 1'b0;
            acertou   <= 1'b0;
            errou     <= 1'b0;
            timeout   <= 1'b0;
            pronto    <= 1'b0;
            db_estado <= 4'h0;
        end else begin
            estado <= proximo;
            if (estado != ESPERA)
                contagem <= '0;
            else if (contagem != LIMITE)
                contagem <= contagem + 1'b1;
            zeraE     <= (proximo == PREPARACAO) || (proximo == INICIO_RODADA);
            contaE    <= (proximo == PROXIMA_JOGADA);
            zeraR     <= (proximo == PREPARACAO);
            contaR    <= (proximo == PROXIMA_RODADA);
            registraR <= (proximo == REGISTRA);
            acertou   <= (proximo == FINAL_ACERTO);
            errou     <= (proximo == FINAL_ERRO);
            timeout   <= (proximo == FINAL_TIMEOUT);
            pronto    <= (proximo == FINAL_ACERTO) || (proximo == FINAL_ERRO) ||
                         (proximo == FINAL_TIMEOUT);
            db_estado <= proximo;
        end
    end

endmodule

// File: tb/tb_controle_jogo_rodadas.sv
// Bench for controle_jogo_rodadas: a game-level model checked every cycle plus directed scenarios
// with literal expected state codes.
module tb_controle_jogo_rodadas;

    localparam int TMO = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       jogada = 1'b0;
    logic       igual = 1'b0;
    logic       fim_jogada = 1'b0;
    logic       fim_rodada = 1'b0;
    logic       zeraE, contaE, zeraR, contaR, registraR;
    logic       acertou, errou, timeout, pronto;
    logic [3:0] db_estado;

    int checkCount = 0;
    int passCount  = 0;

    // Model state: expected state code and espera cycles already completed in this stay.
    int mState = 0;
    int mWait  = 0;

    controle_jogo_rodadas #(.TIMEOUT_CICLOS(TMO)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .igual(igual),
        .fim_jogada(fim_jogada), .fim_rodada(fim_rodada), .zeraE(zeraE), .contaE(contaE),
        .zeraR(zeraR), .contaR(contaR), .registraR(registraR), .acertou(acertou),
        .errou(errou), .timeout(timeout), .pronto(pronto), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
        checkCount++;
        if (actual === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    endtask

    always @(posedge clock or posedge reset) begin
        int nxt;
        if (reset) begin
            mState = 0;
            mWait  = 0;
        end else begin
            case (mState)
                0:          nxt = iniciar ? 1 : 0;
                1:          nxt = 2;
                2:          nxt = 3;
                3:          nxt = jogada ? 4 : ((mWait == TMO - 1) ? 15 : 3);
                4:          nxt = 5;
                5:          nxt = !igual ? 14 : (!fim_jogada ? 6 : (!fim_rodada ? 7 : 10));
                6:          nxt = 3;
                7:          nxt = 2;
                10, 14, 15: nxt = iniciar ? 1 : mState;
                default:    nxt = 0;
            endcase
            mWait  = (mState == 3 && nxt == 3) ? mWait + 1 : 0;
            mState = nxt;
        end
    end

    always @(negedge clock) begin
        checkOutput("m_db_estado", db_estado, 4'(mState));
        checkOutput("m_zeraE", {3'b0, zeraE}, {3'b0, mState == 1 || mState == 2});
        checkOutput("m_zeraR", {3'b0, zeraR}, {3'b0, mState == 1});
        checkOutput("m_contaE", {3'b0, contaE}, {3'b0, mState == 6});
        checkOutput("m_contaR", {3'b0, contaR}, {3'b0, mState == 7});
        checkOutput("m_registraR", {3'b0, registraR}, {3'b0, mState == 4});
        checkOutput("m_acertou", {3'b0, acertou}, {3'b0, mState == 10});
        checkOutput("m_errou", {3'b0, errou}, {3'b0, mState == 14});
        checkOutput("m_timeout", {3'b0, timeout}, {3'b0, mState == 15});
        checkOutput("m_pronto", {3'b0, pronto}, {3'b0, mState == 10 || mState == 14 || mState == 15});
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Drives one cycle of inputs; iniciar and jogada drop afterwards, the compare flags are held.
    task automatic applyStimulus(input logic ini, input logic jog, input logic ig,
                                 input logic fj, input logic fr);
        iniciar    = ini;
        jogada     = jog;
        igual      = ig;
        fim_jogada = fj;
        fim_rodada = fr;
        tick();
        iniciar = 1'b0;
        jogada  = 1'b0;
    endtask

    task automatic startGame(input string tag);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput({tag, "_prep"}, db_estado, 4'h1);
        checkOutput({tag, "_zeraR"}, {3'b0, zeraR}, 4'h1);
        tick();
        checkOutput({tag, "_inicio"}, db_estado, 4'h2);
        tick();
        checkOutput({tag, "_espera"}, db_estado, 4'h3);
    endtask

    task automatic playMove(input string tag, input logic ig, input logic fj, input logic fr,
                            input logic [3:0] result);
        applyStimulus(0, 1, ig, fj, fr);
        checkOutput({tag, "_registra"}, db_estado, 4'h4);
        tick();
        checkOutput({tag, "_comparacao"}, db_estado, 4'h5);
        tick();
        checkOutput({tag, "_result"}, db_estado, result);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        #12;
        checkOutput("reset_db", db_estado, 4'h0);
        checkOutput("reset_pronto", {3'b0, pronto}, 4'h0);
        reset = 1'b0;
        tick(2);
        checkOutput("idle_hold", db_estado, 4'h0);

        // Two-round win
        startGame("win");
        playMove("win_r0", 1, 1, 0, 4'h7);
        checkOutput("win_contaR", {3'b0, contaR}, 4'h1);
        tick();
        checkOutput("win_zeraE", {3'b0, zeraE}, 4'h1);
        tick();
        checkOutput("win_r1_espera", db_estado, 4'h3);
        playMove("win_r1m0", 1, 0, 0, 4'h6);
        checkOutput("win_contaE", {3'b0, contaE}, 4'h1);
        tick();
        playMove("win_r1m1", 1, 1, 1, 4'hA);
        checkOutput("win_acertou", {3'b0, acertou}, 4'h1);
        checkOutput("win_pronto", {3'b0, pronto}, 4'h1);
        tick(2);
        checkOutput("win_hold", db_estado, 4'hA);

        // Error in round 1, then restart from the final state
        startGame("err");
        playMove("err_r0", 1, 1, 0, 4'h7);
        tick(2);
        playMove("err_r1m0", 1, 0, 0, 4'h6);
        tick();
        playMove("err_r1m1", 0, 0, 0, 4'hE);
        checkOutput("err_errou", {3'b0, errou}, 4'h1);
        checkOutput("err_pronto", {3'b0, pronto}, 4'h1);

        // Timeout: ten idle espera cycles
        startGame("tmo");
        tick(TMO - 1);
        checkOutput("tmo_last_cycle", db_estado, 4'h3);
        tick();
        checkOutput("tmo_final", db_estado, 4'hF);
        checkOutput("tmo_timeout", {3'b0, timeout}, 4'h1);

        // jogada on the last allowed cycle wins over the timeout
        startGame("late");
        tick(TMO - 1);
        playMove("late_move", 1, 0, 0, 4'h6);
        tick();
        checkOutput("late_back", db_estado, 4'h3);

        // Count restarts on re-entry to espera
        tick(7);
        playMove("restart_move", 1, 0, 0, 4'h6);
        tick();
        tick(TMO - 1);
        checkOutput("restart_still_espera", db_estado, 4'h3);
        tick();
        checkOutput("restart_tmo", db_estado, 4'hF);

        // Ignored inputs
        startGame("ign");
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("ign_ini_espera", db_estado, 4'h3);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("ign_registra", db_estado, 4'h4);
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("ign_comparacao", db_estado, 4'h5);
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("ign_result", db_estado, 4'h6);
        tick();
        checkOutput("ign_espera", db_estado, 4'h3);

        // Illegal state code recovers to inicial
        @(negedge clock);
        #1;
        force dut.estado = 4'hB;
        mState = 11;
        #1;
        release dut.estado;
        @(posedge clock);
        #1;
        checkOutput("illegal_recover", db_estado, 4'h0);

        // Asynchronous reset mid-espera with count 3
        startGame("rst");
        tick(3);
        reset = 1'b1;
        #1;
        checkOutput("rst_db", db_estado, 4'h0);
        checkOutput("rst_zeraE", {3'b0, zeraE}, 4'h0);
        checkOutput("rst_pronto", {3'b0, pronto}, 4'h0);
        #2;
        reset = 1'b0;
        tick();
        startGame("post_rst");
        tick(2);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
